// File: rtl/fifo_push_arbiter_pkg.sv
// Shared constants and state type for the FIFO push-side arbiter and its helpers.
package fifo_push_arbiter_pkg;

    localparam int FIFO_DATA_W = 267;
    localparam int FIFO_DEPTH  = 32;
    localparam int ARB_IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set bit of valid at or above ptr, wrapping modulo N.
module fifo_push_arbiter_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    localparam int SPAN = 1 << IDX_W;

    logic [SPAN-1:0] valid_pad;

    always_comb begin
        valid_pad = '0;
        for (int i = 0; i < N; i++) begin
            valid_pad[i] = valid[i];
        end
    end

    // Scan from the farthest offset down so the nearest candidate to ptr wins last.
    always_comb begin
        int pos;
        pos   = 0;
        index = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (valid_pad[IDX_W'(pos)]) begin
                index = IDX_W'(pos);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin, packet-locked arbiter driving the push side of a shared register FIFO.
// Optional stall watchdog (errTimeout port, TIMEOUT parameter) enabled by FIFO_PUSH_ARB_WATCHDOG_EN.
module fifo_push_arbiter
    import fifo_push_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = FIFO_DATA_W
`ifdef FIFO_PUSH_ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic                      clockCore,
    input  logic                      resetCore,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ-1:0]        reqLast,
    input  logic [NUM_REQ*DATA_W-1:0] reqData,
    output logic [NUM_REQ-1:0]        reqReady,
    output logic                      fifoPush,
    output logic [DATA_W-1:0]         fifoDataIn,
    input  logic                      fifoFull,
    input  logic                      fifoOverrun,
    output logic [2:0]                grantId,
    output logic                      busy,
    output logic [15:0]               pktCount,
    output logic                      errOverrun
`ifdef FIFO_PUSH_ARB_WATCHDOG_EN
    ,
    output logic                      errTimeout
`endif
);

    localparam int SPAN = 1 << ARB_IDX_W;

    arb_state_t           state;
    logic [ARB_IDX_W-1:0] rr_ptr;
    logic [ARB_IDX_W-1:0] next_ptr;
    logic [ARB_IDX_W-1:0] pick_idx;
    logic                 pick_found;
    logic [SPAN-1:0]      valid_pad;
    logic [SPAN-1:0]      last_pad;
    logic                 beat;
    logic                 owner_valid;
    logic                 owner_last;

    fifo_push_arbiter_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ARB_IDX_W)
    ) u_pick (
        .valid (reqValid),
        .ptr   (rr_ptr),
        .index (pick_idx),
        .found (pick_found)
    );

    // Pad the request vectors to the full index range so grantId can select them directly.
    always_comb begin
        valid_pad = '0;
        last_pad  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            valid_pad[i] = reqValid[i];
            last_pad[i]  = reqLast[i];
        end
    end

    assign owner_valid = valid_pad[grantId];
    assign owner_last  = last_pad[grantId];
    assign beat        = (state == BURST) && !resetCore && owner_valid && !fifoFull;
    assign fifoPush    = beat;
    assign next_ptr    = (grantId == ARB_IDX_W'(NUM_REQ - 1)) ? '0 : grantId + 1'b1;

    always_comb begin
        reqReady   = '0;
        fifoDataIn = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantId == ARB_IDX_W'(i)) begin
                reqReady[i] = beat;
                fifoDataIn  = reqData[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef FIFO_PUSH_ARB_WATCHDOG_EN
    logic [7:0] stall_cnt;
    logic       timeout_hit;

    assign timeout_hit = (state == BURST) && !owner_valid && (int'(stall_cnt) + 1 >= TIMEOUT);

    // Counts owner-idle cycles within a packet; any accepted beat restarts the window.
    always_ff @(posedge clockCore) begin
        if (resetCore) begin
            stall_cnt  <= '0;
            errTimeout <= 1'b0;
        end else begin
            if (state != BURST || beat || timeout_hit) begin
                stall_cnt <= '0;
            end else if (!owner_valid) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
            if (timeout_hit) begin
                errTimeout <= 1'b1;
            end
        end
    end
`endif

    // The grant stays with one requester until its last beat transfers.
    always_ff @(posedge clockCore) begin
        if (resetCore) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grantId    <= '0;
            busy       <= 1'b0;
            pktCount   <= '0;
            errOverrun <= 1'b0;
        end else begin
            if (fifoOverrun) begin
                errOverrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grantId <= pick_idx;
                        busy    <= 1'b1;
                        state   <= BURST;
                    end
                end
                BURST: begin
                    if (beat && owner_last) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        rr_ptr   <= next_ptr;
                        pktCount <= pktCount + 16'd1;
                    end
`ifdef FIFO_PUSH_ARB_WATCHDOG_EN
                    else if (timeout_hit) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
